// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, fault codes
// and the reset-time NOP placed in the IF/ID register.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10
    } fetch_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures instruction, its address and address+4.
// Flush only drops the valid bit; the payload keeps its last captured value.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc,
    input  logic [31:0] next_pc_plus4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0000_0000;
            pc_plus4_q <= 32'h0000_0000;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q    <= 1'b1;
            instr_q    <= next_instr;
            pc_q       <= next_pc;
            pc_plus4_q <= next_pc_plus4;
        end
    end

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and sticky fault
// reporting, feeding the IF/ID pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [1:0]  fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [1:0]   fault_q, fault_d;
    logic [31:0]  pc_plus4;
    logic         in_range;
    logic         redirect_misaligned;
    logic         load;
    logic         flush;

    assign pc_plus4            = pc_q + 32'd4;
    assign in_range            = {2'b00, pc_q[31:2]} < 32'(IMEM_WORDS);
    assign redirect_misaligned = redirect_pc[1:0] != 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Priority in RUN: redirect (misalign checked first), then stall, then range.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        load    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_misaligned) begin
                        fault_d = FAULT_MISALIGN;
                        state_d = StHalt;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (!stall) begin
                    if (!in_range) begin
                        flush   = 1'b1;
                        fault_d = FAULT_RANGE;
                        state_d = StHalt;
                    end else begin
                        load = 1'b1;
                        pc_d = pc_plus4;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .flush         (flush),
        .next_instr    (imem_instr),
        .next_pc       (pc_q),
        .next_pc_plus4 (pc_plus4),
        .valid         (id_valid),
        .instr         (id_instr),
        .pc            (id_pc),
        .pc_plus4      (id_pc_plus4)
    );

    assign imem_pc = pc_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory whose
// word i holds 0x1000_0000 + i.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [1:0]  fault;

    int unsigned n_compared;
    int unsigned n_mismatched;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fault          (fault)
    );

    assign imem_instr = 32'h1000_0000 + {2'b00, imem_pc[31:2]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " imem_pc"}, imem_pc, 32'h0);
        check({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, " id_instr"}, id_instr, 32'h0000_0013);
        check({tag, " id_pc"}, id_pc, 32'h0);
        check({tag, " id_pc_plus4"}, id_pc_plus4, 32'h0);
        check({tag, " fault"}, {30'd0, fault}, 32'd0);
    endtask

    initial begin
        n_compared     = 0;
        n_mismatched   = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // BOOT cycle
        @(negedge clk);
        check("boot id_valid", {31'd0, id_valid}, 32'd0);
        check("boot imem_pc", imem_pc, 32'h0);

        // Sequential fetch
        @(negedge clk);
        check("seq0 id_valid", {31'd0, id_valid}, 32'd1);
        check("seq0 id_pc", id_pc, 32'h0);
        check("seq0 id_instr", id_instr, 32'h1000_0000);
        @(negedge clk);
        check("seq1 id_pc", id_pc, 32'h4);
        check("seq1 id_instr", id_instr, 32'h1000_0001);
        @(negedge clk);
        check("seq2 id_pc", id_pc, 32'h8);
        check("seq2 id_instr", id_instr, 32'h1000_0002);
        check("seq2 id_pc_plus4", id_pc_plus4, 32'hC);
        check("seq2 imem_pc", imem_pc, 32'hC);

        // Three-cycle stall
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall id_pc", id_pc, 32'h8);
            check("stall id_instr", id_instr, 32'h1000_0002);
            check("stall imem_pc", imem_pc, 32'hC);
            check("stall id_valid", {31'd0, id_valid}, 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        check("resume id_pc", id_pc, 32'hC);
        check("resume id_instr", id_instr, 32'h1000_0003);
        check("resume imem_pc", imem_pc, 32'h10);

        // Redirect wins over stall
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        stall          = 1'b1;
        @(negedge clk);
        check("redir id_valid", {31'd0, id_valid}, 32'd0);
        check("redir imem_pc", imem_pc, 32'h14);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        @(negedge clk);
        check("redir+1 id_valid", {31'd0, id_valid}, 32'd1);
        check("redir+1 id_pc", id_pc, 32'h14);
        check("redir+1 id_instr", id_instr, 32'h1000_0005);
        check("redir+1 id_pc_plus4", id_pc_plus4, 32'h18);

        // Jump near the end of memory and run off it
        redirect_valid = 1'b1;
        redirect_pc    = 32'h70;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("last id_valid", {31'd0, id_valid}, 32'd1);
        check("last id_pc", id_pc, 32'h7C);
        check("last id_instr", id_instr, 32'h1000_001F);
        check("last imem_pc", imem_pc, 32'h80);
        check("last fault", {30'd0, fault}, 32'd0);
        @(negedge clk);
        check("range fault", {30'd0, fault}, 32'd2);
        check("range id_valid", {31'd0, id_valid}, 32'd0);
        check("range id_pc", id_pc, 32'h7C);
        check("range imem_pc", imem_pc, 32'h80);

        // HALT ignores redirect and stall
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        stall          = 1'b1;
        @(negedge clk);
        check("halt imem_pc", imem_pc, 32'h80);
        check("halt fault", {30'd0, fault}, 32'd2);
        check("halt id_valid", {31'd0, id_valid}, 32'd0);
        redirect_valid = 1'b0;
        stall          = 1'b0;

        // Asynchronous reset pulse between edges while halted
        #2 rst = 1'b1;
        #1 check_reset_outputs("async rst");
        #1 rst = 1'b0;
        @(negedge clk);
        check("reboot id_valid", {31'd0, id_valid}, 32'd0);
        check("reboot imem_pc", imem_pc, 32'h0);
        @(negedge clk);
        check("reboot id_pc", id_pc, 32'h0);
        check("reboot id_valid+1", {31'd0, id_valid}, 32'd1);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h16;
        @(negedge clk);
        check("misalign fault", {30'd0, fault}, 32'd1);
        check("misalign id_valid", {31'd0, id_valid}, 32'd0);
        check("misalign imem_pc", imem_pc, 32'h4);
        redirect_pc = 32'h20;
        @(negedge clk);
        check("misalign hold imem_pc", imem_pc, 32'h4);
        check("misalign hold fault", {30'd0, fault}, 32'd1);
        redirect_valid = 1'b0;

        // Misaligned redirect coincident with out-of-range PC reports misalign
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        @(negedge clk);
        check("oob redir imem_pc", imem_pc, 32'h80);
        check("oob redir fault", {30'd0, fault}, 32'd0);
        redirect_pc = 32'h16;
        @(negedge clk);
        check("both fault", {30'd0, fault}, 32'd1);
        check("both imem_pc", imem_pc, 32'h80);
        redirect_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 32: number of 32-bit words in instruction memory; legal word index 0..IMEM_WORDS-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_pc  output  32  fetch address driven to instruction memory (word index = imem_pc[31:2]).
REQ-006 SHALL have port imem_instr  input  32  combinational read data from instruction memory for imem_pc, same cycle.
REQ-007 SHALL have port stall  input  1  decode not ready; hold PC and IF/ID contents.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-009 SHALL have port redirect_pc  input  32  redirect target.
REQ-010 SHALL have port id_valid  output  1  IF/ID register holds a valid instruction.
REQ-011 SHALL have port id_instr  output  32  registered instruction.
REQ-012 SHALL have port id_pc  output  32  registered address of id_instr.
REQ-013 SHALL have port id_pc_plus4  output  32  id_pc + 4, registered.
REQ-014 SHALL have port fault  output  2  sticky fault code: 00 none, 01 misaligned redirect, 10 fetch out of range.

Function
REQ-015 SHALL keep a 3-state FSM: BOOT, RUN, HALT.
REQ-016 BOOT SHALL last exactly one cycle after reset release with id_valid=0, pc=RESET_PC, then go to RUN.
REQ-017 imem_pc SHALL equal the PC register combinationally (zero-cycle address path).
REQ-018 In RUN with stall=0, redirect_valid=0, in-range PC: IF/ID SHALL capture {imem_instr, pc, pc+4}, id_valid<=1, pc<=pc+4 (1-cycle fetch-to-decode latency).
REQ-019 In RUN with stall=1, redirect_valid=0: pc and all id_* outputs SHALL hold unchanged.
REQ-020 redirect_valid=1 SHALL take priority over stall: pc<=redirect_pc, id_valid<=0 (flush) on that edge; the next cycle fetches redirect_pc.
REQ-021 redirect_valid=1 with redirect_pc[1:0]!=0 SHALL set fault=01, id_valid<=0, pc unchanged, FSM->HALT.
REQ-022 In RUN, pc[31:2] >= IMEM_WORDS SHALL set fault=10, id_valid<=0, FSM->HALT, instead of capturing.
REQ-023 Simultaneous misaligned redirect and out-of-range pc SHALL report 01 (redirect evaluated first).
REQ-024 HALT SHALL be left only by reset; id_valid=0, pc frozen, redirect/stall ignored.
REQ-025 pc+4 SHALL be 32-bit modulo (0xFFFF_FFFC+4 = 0); range check precedes use.

Reset
REQ-026 rst=1 SHALL asynchronously force pc=RESET_PC, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, id_pc_plus4=0, fault=00, FSM=BOOT.
REQ-027 rst asserted mid-operation, including in HALT or during stall, SHALL apply REQ-026 immediately, independent of clk.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, fault codes (FAULT_NONE/MISALIGN/RANGE) and the NOP constant 32'h0000_0013.
REQ-029 IF/ID pipeline register SHALL be a sub-module if_id_reg (load enable, flush, async reset); PC/FSM logic stays in fetch_stage.

Verification
REQ-030 Reset release, no stall, memory word i = 0x1000_0000+i: id_valid rises 2nd cycle after release, id_pc 0,4,8; id_instr 0x1000_0000, 0x1000_0001, 0x1000_0002.
REQ-031 stall=1 for 3 cycles at id_pc=8: imem_pc=12 held, id_pc=8/id_instr held all 3 cycles; resumes with id_pc=12.
REQ-032 redirect_valid=1, redirect_pc=0x14, stall=1 same cycle: next cycle id_valid=0, imem_pc=0x14; following cycle id_pc=0x14, id_valid=1.
REQ-033 redirect_pc=0x16: fault=01, id_valid=0, imem_pc frozen thereafter; later redirect to 0x20 ignored.
REQ-034 Sequential run to pc=0x80 (IMEM_WORDS=32): fault=10, id_valid=0, last valid id_pc=0x7C.
REQ-035 rst pulsed between clock edges while in HALT: outputs per REQ-026 immediately, fault=00, fetch restarts at RESET_PC.
